microcode_store: RTL and testbench
==================================

MICROCODE_STORE -- requirements
Module: microcode_store

Interface
REQ-001 SHALL have parameter WIDTH, default 64, control-word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port rd_en, input, 1, read request.
REQ-006 SHALL have port rd_addr, input, ADDR_W, read address.
REQ-007 SHALL have port rd_data, output, WIDTH, registered read word.
REQ-008 SHALL have port rd_valid, output, 1, rd_data holds the requested word this cycle.
REQ-009 SHALL have port ld_start, input, 1, begin a load burst.
REQ-010 SHALL have port ld_base, input, ADDR_W, first address of the burst.
REQ-011 SHALL have port ld_valid, input, 1, ld_data is offered.
REQ-012 SHALL have port ld_data, input, WIDTH, word to write.
REQ-013 SHALL have port ld_last, input, 1, the offered word ends the burst.
REQ-014 SHALL have port ld_ready, output, 1, the store accepts a load word this cycle.
REQ-015 SHALL have port ld_done, output, 1, one-cycle pulse after the last word is written.
REQ-016 SHALL have port busy, output, 1, high in INIT or LOAD.

Function
REQ-017 SHALL implement states INIT, IDLE and LOAD.
REQ-018 INIT: SHALL write zero to address clr_ptr each cycle, clr_ptr 0..DEPTH-1; after writing DEPTH-1 -> IDLE. INIT SHALL last exactly DEPTH cycles.
REQ-019 IDLE: ld_start=1 SHALL latch ld_base into ld_ptr and enter LOAD next cycle; no write occurs in the ld_start cycle.
REQ-020 LOAD: ld_ready SHALL be 1. A beat is accepted when ld_valid&&ld_ready; the beat SHALL write ld_data to ram[ld_ptr], then ld_ptr <= ld_ptr+1 modulo DEPTH (DEPTH-1 wraps to 0).
REQ-021 An accepted beat with ld_last=1 SHALL return to IDLE and assert ld_done on the next cycle only.
REQ-022 ld_ready SHALL be 0 in INIT and IDLE; ld_valid outside LOAD SHALL be ignored. ld_start outside IDLE SHALL be ignored.
REQ-023 rd_en in IDLE or LOAD SHALL give rd_data=ram[rd_addr] and rd_valid=1 on the next cycle (latency 1); rd_valid=0 on all other cycles.
REQ-024 rd_en in INIT SHALL be ignored: rd_valid stays 0 and rd_data holds its value.
REQ-025 rd_data SHALL hold its last value when rd_valid=0.
REQ-026 A read and an accepted load beat to the same address in the same cycle SHALL return the new ld_data (write-first).
REQ-027 Reads and load beats SHALL proceed concurrently without stalls.
REQ-028 busy SHALL be 1 in INIT or LOAD and 0 in IDLE.

Reset
REQ-029 rst=1 SHALL, from any state, force INIT with clr_ptr=0, ld_ptr=0, rd_valid=0, ld_done=0 and rd_data=0; ld_ready=0 and busy=1 from the next cycle.
REQ-030 rst asserted mid-LOAD SHALL abandon the burst, give no ld_done, and re-clear the whole array.
REQ-031 Array contents are not reset directly; the INIT sweep SHALL zero them.

Structure
REQ-032 A shared package SHALL hold the state encoding (INIT/IDLE/LOAD) and the default WIDTH/ADDR_W constants.
REQ-033 The storage array SHALL be one sub-module, mc_store_array: a single-clock memory with one write port and one registered read port, write-first. The FSM and pointers SHALL live in microcode_store.

Verification
REQ-034 Release rst, hold rd_en=1 at rd_addr=0x1FF -> busy=1 and rd_valid=0 for 512 cycles, then busy=0, then rd_valid=1 with rd_data=0.
REQ-035 After INIT: ld_start with ld_base=0x010, then 3 beats 0xA1, 0xA2, 0xA3 (last on third) -> ld_done pulses once; reads of 0x010..0x012 return 0xA1..0xA3; 0x013 reads 0.
REQ-036 ld_base=0x1FE, 3 beats 0xB0..0xB2 -> writes land at 0x1FE, 0x1FF, 0x000 (wrap).
REQ-037 During LOAD, ld_ptr=0x020: rd_en at 0x020 with ld_data=0xDEAD accepted in the same cycle -> next cycle rd_data=0xDEAD.
REQ-038 Assert rst after 2 of 4 beats -> no ld_done; a 512-cycle INIT follows; afterwards the earlier written addresses read 0.
REQ-039 ld_valid=1 with ld_data=0xFF in IDLE -> ld_ready=0 and no array change; ld_valid gaps in LOAD -> ld_ptr advances only on accepted beats.

Source files
------------

// File: rtl/microcode_store_pkg.sv
// Shared definitions for the microcode store: controller state encoding and
// default geometry of the control-word array.
package microcode_store_pkg;

    localparam int DEFAULT_WIDTH  = 64;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/mc_store_array.sv
// Single-clock control-word memory: one write port, one registered read port,
// write-first when both ports hit the same address in the same cycle.
module mc_store_array import microcode_store_pkg::*; #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Storage itself is never reset; the controller's INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/microcode_store.sv
// Microcode store controller: clears the array after reset, accepts burst
// loads at an auto-incrementing pointer, and serves latency-1 reads.
module microcode_store import microcode_store_pkg::*; #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] ld_ptr;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re;
    logic              beat;

    assign beat  = (state == ST_LOAD) && ld_valid;
    assign we    = !rst && ((state == ST_INIT) || beat);
    assign waddr = (state == ST_INIT) ? clr_ptr : ld_ptr;
    assign wdata = (state == ST_INIT) ? '0 : ld_data;
    assign re    = !rst && rd_en && (state != ST_INIT);

    // ld_ready and busy are registered alongside each transition so they
    // always agree with the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            clr_ptr  <= '0;
            ld_ptr   <= '0;
            rd_valid <= 1'b0;
            ld_done  <= 1'b0;
            ld_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            ld_done  <= 1'b0;
            rd_valid <= re;
            case (state)
                ST_INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == {ADDR_W{1'b1}}) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (ld_start) begin
                        ld_ptr   <= ld_base;
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        ld_ptr <= ld_ptr + 1'b1;
                        if (ld_last) begin
                            state    <= ST_IDLE;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            ld_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    clr_ptr  <= '0;
                    ld_ready <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

    mc_store_array #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_microcode_store.sv
// Self-checking bench for microcode_store: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_microcode_store;

    localparam int WIDTH  = 64;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic              ld_valid;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [WIDTH-1:0] mem_model [DEPTH];
    int               init_left;
    bit               loading;
    int               ptr;
    logic [WIDTH-1:0] exp_rd_data;
    logic             exp_rd_valid;
    logic             exp_ld_done;
    logic             exp_busy;
    logic             exp_ld_ready;

    microcode_store #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge using the inputs held across it.
    task automatic modelEdge();
        bit in_init;
        bit was_idle;
        if (rst) begin
            init_left    = DEPTH;
            loading      = 1'b0;
            ptr          = 0;
            exp_rd_valid = 1'b0;
            exp_ld_done  = 1'b0;
            exp_rd_data  = '0;
        end else begin
            in_init     = (init_left > 0);
            was_idle    = !in_init && !loading;
            exp_ld_done = 1'b0;
            if (in_init) begin
                init_left--;
                if (init_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
                end
            end else if (loading && ld_valid) begin
                mem_model[ptr] = ld_data;
                ptr = (ptr + 1) % DEPTH;
                if (ld_last) begin
                    loading     = 1'b0;
                    exp_ld_done = 1'b1;
                end
            end
            if (was_idle && ld_start) begin
                loading = 1'b1;
                ptr     = int'(ld_base);
            end
            exp_rd_valid = !in_init && rd_en;
            if (exp_rd_valid) exp_rd_data = mem_model[rd_addr];
        end
        exp_busy     = (init_left > 0) || loading;
        exp_ld_ready = (init_left == 0) && loading;
    endtask

    task automatic checkOutput();
        compared++;
        assert (rd_valid === exp_rd_valid) else begin
            mismatched++;
            $error("[TB] FAIL rd_valid: observed %b expected %b", rd_valid, exp_rd_valid);
        end
        compared++;
        assert (rd_data === exp_rd_data) else begin
            mismatched++;
            $error("[TB] FAIL rd_data: observed %h expected %h", rd_data, exp_rd_data);
        end
        compared++;
        assert (busy === exp_busy) else begin
            mismatched++;
            $error("[TB] FAIL busy: observed %b expected %b", busy, exp_busy);
        end
        compared++;
        assert (ld_ready === exp_ld_ready) else begin
            mismatched++;
            $error("[TB] FAIL ld_ready: observed %b expected %b", ld_ready, exp_ld_ready);
        end
        compared++;
        assert (ld_done === exp_ld_done) else begin
            mismatched++;
            $error("[TB] FAIL ld_done: observed %b expected %b", ld_done, exp_ld_done);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic re, input logic [ADDR_W-1:0] ra,
                                 input logic ls, input logic [ADDR_W-1:0] lb,
                                 input logic lv, input logic [WIDTH-1:0] ld, input logic ll);
        rst      = r;
        rd_en    = re;
        rd_addr  = ra;
        ld_start = ls;
        ld_base  = lb;
        ld_valid = lv;
        ld_data  = ld;
        ld_last  = ll;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, '0, 0, '0, 0, '0, 0);
    endtask

    task automatic readAt(input logic [ADDR_W-1:0] a);
        applyStimulus(0, 1, a, 0, '0, 0, '0, 0);
    endtask

    task automatic beat(input logic [WIDTH-1:0] d, input logic last);
        applyStimulus(0, 0, '0, 0, '0, 1, d, last);
    endtask

    task automatic startLoad(input logic [ADDR_W-1:0] base);
        applyStimulus(0, 0, '0, 1, base, 0, '0, 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        init_left = DEPTH;
        loading   = 1'b0;
        ptr       = 0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 'x;

        $display("[TB] reset and INIT sweep");
        applyStimulus(1, 0, '0, 0, '0, 0, '0, 0);
        applyStimulus(1, 1, 9'h1FF, 0, '0, 0, '0, 0);
        repeat (DEPTH + 3) applyStimulus(0, 1, 9'h1FF, 0, '0, 0, '0, 0);

        $display("[TB] basic burst at 0x010");
        startLoad(9'h010);
        beat(64'hA1, 0);
        beat(64'hA2, 0);
        beat(64'hA3, 1);
        idleCycle();
        for (int a = 'h010; a <= 'h013; a++) readAt(ADDR_W'(a));

        $display("[TB] wrapping burst at 0x1FE");
        startLoad(9'h1FE);
        beat(64'hB0, 0);
        beat(64'hB1, 0);
        beat(64'hB2, 1);
        readAt(9'h1FE);
        readAt(9'h1FF);
        readAt(9'h000);

        $display("[TB] write-first collision at 0x020");
        startLoad(9'h020);
        applyStimulus(0, 1, 9'h020, 0, '0, 1, 64'hDEAD, 1);
        readAt(9'h020);

        $display("[TB] ld_valid in IDLE and gapped beats");
        applyStimulus(0, 0, '0, 0, '0, 1, 64'hFF, 0);
        applyStimulus(0, 1, 9'h030, 0, '0, 1, 64'hFF, 1);
        readAt(9'h030);
        applyStimulus(0, 0, '0, 1, 9'h040, 1, 64'hEE, 0);
        beat(64'h40, 0);
        idleCycle();
        idleCycle();
        beat(64'h41, 0);
        applyStimulus(0, 0, '0, 0, '0, 0, 64'h99, 1);
        beat(64'h42, 1);
        for (int a = 'h040; a <= 'h043; a++) readAt(ADDR_W'(a));

        $display("[TB] reset mid-burst");
        startLoad(9'h050);
        beat(64'hC0, 0);
        beat(64'hC1, 0);
        applyStimulus(1, 0, '0, 0, '0, 1, 64'hC2, 0);
        repeat (DEPTH + 2) applyStimulus(0, 0, '0, 0, '0, 1, 64'hC3, 1);
        readAt(9'h050);
        readAt(9'h051);
        readAt(9'h010);
        readAt(9'h1FE);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            ra = ADDR_W'($urandom_range(0, 63)) - ADDR_W'(16);
            applyStimulus(($urandom_range(0, 999) == 0),
                          1'($urandom_range(0, 1)),
                          ra,
                          ($urandom_range(0, 3) == 0),
                          ADDR_W'($urandom_range(0, 63)) - ADDR_W'(16),
                          ($urandom_range(0, 9) < 6),
                          {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
